product_accumulator: RTL and testbench



---
 rtl/prod_acc_pkg.sv | 14 +
 rtl/product_accumulator.sv | 82 ++++++++
 tb/tb_product_accumulator.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prod_acc_pkg.sv
// Shared constants and FSM state type for the product accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prod_acc_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/product_accumulator.sv
// Sums each group of TERMS unsigned products into one result with a sticky carry-out flag.
// Latency: out_valid rises on the edge that accepts the last term of a group.
// Backpressure: while a result waits for out_ready, in_ready is held low and nothing is accepted.
module product_accumulator
  import prod_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int TERMS  = 4,
  parameter int CNT_W  = $clog2(TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  acc_state_t       state_q;
  acc_state_t       state_d;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_acc;
  logic [ACC_W:0]   sum_w;
  logic             accept;
  logic             last;

  assign in_ready = (state_q == ACCUM) && !rst;
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CNT_W'(TERMS - 1));

  // One extra bit on top of the accumulator catches the carry of each addition.
  assign sum_w = {1'b0, acc} + (ACC_W + 1)'(in_product);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (accept && last) state_d = HOLD;
      HOLD:  if (out_valid && out_ready) state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      if (last) begin
        out_sum   <= sum_w[ACC_W-1:0];
        out_ovf   <= ovf_acc | sum_w[ACC_W];
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        ovf_acc   <= 1'b0;
      end else begin
        acc       <= sum_w[ACC_W-1:0];
        ovf_acc   <= ovf_acc | sum_w[ACC_W];
        cnt       <= cnt + CNT_W'(1);
      end
    end else if (out_valid && out_ready) begin
      // out_sum/out_ovf deliberately keep their values; only out_valid drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three parameterisations driven from one stimulus thread,
// expected results queued by an arithmetic group model and checked by a negedge monitor.
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        iv  [3];
  logic        ir  [3];
  logic        ov  [3];
  logic        orr [3];
  logic        ovf [3];
  logic [7:0]  ip  [3];
  logic [11:0] os0;
  logic [7:0]  os1;
  logic [11:0] os2;

  // k=0: ACC_W=12 TERMS=4   k=1: ACC_W=8 TERMS=2   k=2: ACC_W=12 TERMS=1
  product_accumulator #(.PROD_W(8), .ACC_W(12), .TERMS(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_product(ip[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_sum(os0), .out_ovf(ovf[0]));
  product_accumulator #(.PROD_W(8), .ACC_W(8), .TERMS(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_product(ip[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_sum(os1), .out_ovf(ovf[1]));
  product_accumulator #(.PROD_W(8), .ACC_W(12), .TERMS(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_product(ip[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_sum(os2), .out_ovf(ovf[2]));

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int rmode [3];       // 0 always ready, 1 random ready, 2 stalled
  int due_cyc [3];
  int unsigned tot [3];
  int nterm [3];
  logic [12:0] q0[$], q1[$], q2[$];   // {ovf, sum}

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int terms_of(int k);
    case (k)
      0: return 4;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int accw_of(int k);
    return (k == 1) ? 8 : 12;
  endfunction

  function automatic logic [11:0] sum_of(int k);
    case (k)
      0: return os0;
      1: return {4'b0, os1};
      default: return os2;
    endcase
  endfunction

  function automatic int qsize(int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a group's result is its plain integer total; a carry happened somewhere
  // in the group exactly when that total reaches 2^ACC_W (all products are non-negative).
  task automatic model_accept(int k, logic [7:0] p);
    int unsigned lim;
    logic [12:0] e;
    tot[k] += p;
    nterm[k]++;
    if (nterm[k] == terms_of(k)) begin
      lim = 32'd1 << accw_of(k);
      e = {(tot[k] >= lim), 12'(tot[k] % lim)};
      case (k)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
      tot[k] = 0;
      nterm[k] = 0;
      due_cyc[k] = cyc + 1;
    end
  endtask

  task automatic send(int k, logic [7:0] p);
    int t = 0;
    iv[k] = 1'b1;
    ip[k] = p;
    while (!ir[k] && t < 50) begin
      tick();
      t++;
    end
    check($sformatf("send_accept_%0d", k), ir[k], 1);
    if (ir[k]) begin
      model_accept(k, p);
      tick();
    end
    iv[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tot[k] = 0;
      nterm[k] = 0;
      due_cyc[k] = -1;
    end
    q0.delete();
    q1.delete();
    q2.delete();
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid_%0d", k), ov[k], 0);
      check($sformatf("rst_sum_%0d", k), sum_of(k), 0);
      check($sformatf("rst_ovf_%0d", k), ovf[k], 0);
      check($sformatf("rst_in_ready_%0d", k), ir[k], 0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("post_rst_in_ready_%0d", k), ir[k], 1);
      check($sformatf("post_rst_valid_%0d", k), ov[k], 0);
    end
  endtask

  task automatic drain();
    int t = 0;
    for (int k = 0; k < 3; k++) rmode[k] = 0;
    while ((qsize(0) + qsize(1) + qsize(2)) != 0 && t < 500) begin
      tick();
      t++;
    end
    check("drain_pending", qsize(0) + qsize(1) + qsize(2), 0);
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++)
      orr[k] = (rmode[k] == 0) ? 1'b1 : (rmode[k] == 1) ? 1'($urandom % 2) : 1'b0;
  end

  logic        prev_hold [3];
  logic [11:0] prev_sum  [3];
  logic        prev_ovf  [3];
  logic [12:0] popped;
  logic [11:0] cur_sum;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      cur_sum = sum_of(k);
      if (!rst) check($sformatf("in_ready_vs_hold_%0d", k), ir[k], !ov[k]);
      if (cyc == due_cyc[k]) check($sformatf("result_latency_%0d", k), ov[k], 1);
      if (prev_hold[k] === 1'b1 && ov[k] === 1'b1) begin
        check($sformatf("hold_sum_stable_%0d", k), cur_sum, prev_sum[k]);
        check($sformatf("hold_ovf_stable_%0d", k), ovf[k], prev_ovf[k]);
      end
      prev_hold[k] = ov[k] && !orr[k];
      prev_sum[k]  = cur_sum;
      prev_ovf[k]  = ovf[k];
      if (ov[k] === 1'b1 && orr[k] === 1'b1 && !rst) begin
        if (qsize(k) == 0) begin
          checks++;
          $display("FAIL unexpected_result_%0d: got sum %0d, expected no result", k, cur_sum);
        end else begin
          case (k)
            0: popped = q0.pop_front();
            1: popped = q1.pop_front();
            default: popped = q2.pop_front();
          endcase
          check($sformatf("out_sum_%0d", k), cur_sum, popped[11:0]);
          check($sformatf("out_ovf_%0d", k), ovf[k], popped[12]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      ip[k] = '0;
      rmode[k] = 0;
      due_cyc[k] = -1;
      prev_hold[k] = 1'b0;
    end
    do_reset();

    // Basic group: 3+5+7+9 = 24
    send(0, 8'd3); send(0, 8'd5); send(0, 8'd7); send(0, 8'd9);
    drain();

    // Gaps inside a group and a 5-cycle stall on the output
    rmode[0] = 2;
    send(0, 8'd225); tick(); tick();
    send(0, 8'd225); tick();
    send(0, 8'd225); tick(); tick(); tick();
    send(0, 8'd225);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", ov[0], 1);
      check("stall_sum", os0, 900);
      check("stall_in_ready", ir[0], 0);
      tick();
    end
    drain();

    // Overflow with ACC_W=8: 200+100 wraps to 44, then 1+2 = 3 clean
    send(1, 8'd200); send(1, 8'd100);
    send(1, 8'd1);   send(1, 8'd2);
    drain();

    // Reset mid-group discards 10+20
    send(0, 8'd10); send(0, 8'd20);
    do_reset();
    for (int i = 0; i < 4; i++) send(0, 8'd1);
    drain();

    // Single-term groups
    send(2, 8'd7); send(2, 8'd8); send(2, 8'd9);
    drain();

    // Reset while a result is pending: it must never be delivered
    rmode[0] = 2;
    for (int i = 0; i < 4; i++) send(0, 8'(50 + i));
    tick();
    check("pending_valid", ov[0], 1);
    do_reset();
    rmode[0] = 0;
    for (int i = 0; i < 8; i++) tick();
    check("after_hold_reset_valid", ov[0], 0);

    // Randomized traffic with random backpressure
    for (int k = 0; k < 3; k++) rmode[k] = 1;
    for (int i = 0; i < 150; i++) begin
      int k;
      int gap;
      k = int'($urandom % 3);
      send(k, 8'($urandom % 256));
      gap = int'($urandom % 3);
      for (int g = 0; g < gap; g++) tick();
    end
    drain();
    for (int i = 0; i < 4; i++) tick();
    for (int k = 0; k < 3; k++) check($sformatf("idle_valid_%0d", k), ov[k], 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
